// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the processor-to-memory port arbiter.
package mem_arb_pkg;

    localparam int XLEN      = 32;
    // Widest tag the pending-record struct can hold; narrower tags are zero-extended.
    localparam int TAG_W_MAX = 8;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } BUS_COMMAND;

    typedef enum logic [1:0] {
        BYTE   = 2'd0,
        HALF   = 2'd1,
        WORD   = 2'd2,
        DOUBLE = 2'd3
    } MEM_SIZE;

    // func3[1:0] encodes access size, func3[2] set means zero-extend.
    localparam logic [1:0] F3_SIZE_BYTE    = 2'b00;
    localparam logic [1:0] F3_SIZE_HALF    = 2'b01;
    localparam logic [1:0] F3_SIZE_WORD    = 2'b10;
    localparam int         F3_UNSIGNED_BIT = 2;

    typedef struct packed {
        logic                 valid;
        logic [TAG_W_MAX-1:0] tag;
        logic [2:0]           addr_lo;
        logic [2:0]           func3;
    } ARB_PEND;

    function automatic MEM_SIZE f3_to_size(input logic [2:0] f3);
        return MEM_SIZE'(f3[1:0]);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_load_align.sv
// Selects the addressed word/half/byte from a 64-bit block and extends it to XLEN.
module load_align
    import mem_arb_pkg::*;
(
    input  logic [63:0]     block_i,
    input  logic [2:0]      addr_lo_i,
    input  logic [2:0]      func3_i,
    output logic [XLEN-1:0] data_o
);

    logic [31:0] word;
    logic [15:0] half;
    logic [7:0]  byte_v;
    logic        sign_ext;

    // Word by addr[2], then half/byte by addr[1:0], then extension by func3.
    always_comb begin
        word     = addr_lo_i[2] ? block_i[63:32] : block_i[31:0];
        half     = addr_lo_i[1] ? word[31:16] : word[15:0];
        case (addr_lo_i[1:0])
            2'd0:    byte_v = word[7:0];
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            default: byte_v = word[31:24];
        endcase
        sign_ext = ~func3_i[F3_UNSIGNED_BIT];
        case (func3_i[1:0])
            F3_SIZE_BYTE: data_o = {{(XLEN-8){sign_ext & byte_v[7]}}, byte_v};
            F3_SIZE_HALF: data_o = {{(XLEN-16){sign_ext & half[15]}}, half};
            F3_SIZE_WORD: data_o = word;
            default:      data_o = word;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store requests onto the single memory bus, tracks one
// outstanding tagged load per side and returns aligned load data.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int TAG_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_req,
    input  logic [XLEN-1:0]  if_addr,
    output logic             if_grant,
    output logic             if_valid,
    output logic [63:0]      if_data,
    input  logic             d_read,
    input  logic             d_write,
    input  logic [XLEN-1:0]  d_addr,
    input  logic [2:0]       d_func3,
    input  logic [XLEN-1:0]  d_store_data,
    output logic             d_grant,
    output logic             d_hit,
    output logic [XLEN-1:0]  d_load_data,
    output logic [1:0]       proc2mem_command,
    output logic [XLEN-1:0]  proc2mem_addr,
    output logic [63:0]      proc2mem_data,
    output logic [1:0]       proc2mem_size,
    input  logic [TAG_W-1:0] mem2proc_response,
    input  logic [63:0]      mem2proc_data,
    input  logic [TAG_W-1:0] mem2proc_tag
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    logic             i_pend_q, i_pend_d;
    logic [TAG_W-1:0] i_tag_q, i_tag_d;
    ARB_PEND          d_pend_q, d_pend_d;
    logic [SW-1:0]    starve_q, starve_d;
    logic             if_valid_q, if_valid_d;
    logic [63:0]      if_data_q, if_data_d;
    logic             d_hit_q, d_hit_d;
    logic [XLEN-1:0]  d_load_data_q, d_load_data_d;

    logic             fetch_elig, ls_elig, sel_fetch, sel_ls, accept;
    logic             i_ret, d_ret;
    BUS_COMMAND       bus_cmd;
    MEM_SIZE          bus_size;
    logic [XLEN-1:0]  bus_addr;
    logic [63:0]      bus_data;
    logic [XLEN-1:0]  aligned;

    load_align u_align (
        .block_i   (mem2proc_data),
        .addr_lo_i (d_pend_q.addr_lo),
        .func3_i   (d_pend_q.func3),
        .data_o    (aligned)
    );

    // Eligibility and selection; rst_n gating keeps grants and the bus quiet while in reset.
    always_comb begin
        fetch_elig = rst_n & if_req & ~i_pend_q;
        ls_elig    = rst_n & (d_read | d_write) & ~d_pend_q.valid;
        sel_fetch  = fetch_elig & (~ls_elig | (starve_q == SW'(STARVE_MAX)));
        sel_ls     = ls_elig & ~sel_fetch;
        accept     = (mem2proc_response != '0);
        if_grant   = sel_fetch & accept;
        d_grant    = sel_ls & accept;
        i_ret      = i_pend_q & (mem2proc_tag != '0) & (mem2proc_tag == i_tag_q);
        d_ret      = d_pend_q.valid & (mem2proc_tag != '0) &
                     (d_pend_q.tag == TAG_W_MAX'(mem2proc_tag));
    end

    // Bus drive from the selected request only.
    always_comb begin
        bus_cmd  = BUS_NONE;
        bus_size = BYTE;
        bus_addr = '0;
        bus_data = '0;
        if (sel_fetch) begin
            bus_cmd  = BUS_LOAD;
            bus_size = DOUBLE;
            bus_addr = if_addr;
        end else if (sel_ls) begin
            bus_cmd  = d_write ? BUS_STORE : BUS_LOAD;
            bus_size = f3_to_size(d_func3);
            bus_addr = d_addr;
            if (d_write) bus_data = {{(64-XLEN){1'b0}}, d_store_data};
        end
    end

    assign proc2mem_command = bus_cmd;
    assign proc2mem_size    = bus_size;
    assign proc2mem_addr    = bus_addr;
    assign proc2mem_data    = bus_data;

    // Next-state for pend records, starvation counter and response registers.
    always_comb begin
        i_pend_d      = i_pend_q;
        i_tag_d       = i_tag_q;
        d_pend_d      = d_pend_q;
        starve_d      = starve_q;
        if (if_grant) begin
            i_pend_d = 1'b1;
            i_tag_d  = mem2proc_response;
        end else if (i_ret) begin
            i_pend_d = 1'b0;
        end
        if (d_grant && d_read) begin
            d_pend_d.valid   = 1'b1;
            d_pend_d.tag     = TAG_W_MAX'(mem2proc_response);
            d_pend_d.addr_lo = d_addr[2:0];
            d_pend_d.func3   = d_func3;
        end else if (d_ret) begin
            d_pend_d.valid = 1'b0;
        end
        if (!fetch_elig || if_grant) starve_d = '0;
        else if (starve_q != SW'(STARVE_MAX)) starve_d = starve_q + 1'b1;
        if_valid_d    = i_ret;
        if_data_d     = i_ret ? mem2proc_data : '0;
        d_hit_d       = d_ret | (d_grant & d_write);
        d_load_data_d = d_ret ? aligned : '0;
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_pend_q      <= 1'b0;
            i_tag_q       <= '0;
            d_pend_q      <= '0;
            starve_q      <= '0;
            if_valid_q    <= 1'b0;
            if_data_q     <= '0;
            d_hit_q       <= 1'b0;
            d_load_data_q <= '0;
        end else begin
            i_pend_q      <= i_pend_d;
            i_tag_q       <= i_tag_d;
            d_pend_q      <= d_pend_d;
            starve_q      <= starve_d;
            if_valid_q    <= if_valid_d;
            if_data_q     <= if_data_d;
            d_hit_q       <= d_hit_d;
            d_load_data_q <= d_load_data_d;
        end
    end

    assign if_valid    = if_valid_q;
    assign if_data     = if_data_q;
    assign d_hit       = d_hit_q;
    assign d_load_data = d_load_data_q;

endmodule
